// File: rtl/cell_hist_reader.sv
// Cell histogram reader: walks every 2x2 block of cells in a window and streams the
// histogram words of each block to the normaliser, one outstanding memory read at a time.
// Optional feature: define BLOCK_NORM_SUM_EN to build the per-block bin-sum accumulator
// driving oBlkSum; without it oBlkSum is tied to zero.
module cell_hist_reader #(
    parameter int unsigned CELLS_X = 8,
    parameter int unsigned CELLS_Y = 16,
    parameter int unsigned BINS    = 9,
    parameter int unsigned DW      = 16
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iStart,
    input  logic [7:0]    iCellCnt,
    output logic          oRdEn,
    output logic [10:0]   oRdAddr,
    input  logic [DW-1:0] iRdData,
    output logic [DW-1:0] oData,
    output logic          oValid,
    input  logic          iReady,
    output logic [2:0]    oBlkX,
    output logic [3:0]    oBlkY,
    output logic [1:0]    oCellSel,
    output logic [3:0]    oBin,
    output logic          oBusy,
    output logic          oDone,
    output logic [DW+5:0] oBlkSum
);

    typedef enum logic [2:0] {StIdle, StWait, StRd, StCap, StHold, StDone} stateT;

    stateT         stateQ, stateD;
    logic [2:0]    bxQ, bxD;
    logic [3:0]    byQ, byD;
    logic [1:0]    cellQ, cellD;
    logic [3:0]    binQ, binD;
    logic [DW-1:0] dataQ, dataD;
    logic          validQ, validD;
    logic [15:0]   cellIdx;
    logic [10:0]   rdAddr;

    // Cell under the current block position and its word address in histogram memory.
    always_comb begin
        cellIdx = 16'((32'(byQ) + 32'(cellQ[1])) * CELLS_X + 32'(bxQ) + 32'(cellQ[0]));
        rdAddr  = 11'(32'(cellIdx) * BINS + 32'(binQ));
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            stateQ <= StIdle;
            bxQ    <= '0;
            byQ    <= '0;
            cellQ  <= '0;
            binQ   <= '0;
            dataQ  <= '0;
            validQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            bxQ    <= bxD;
            byQ    <= byD;
            cellQ  <= cellD;
            binQ   <= binD;
            dataQ  <= dataD;
            validQ <= validD;
        end
    end

    // Next-state logic: wait for the cell, read, capture, hold until accepted, then advance.
    always_comb begin
        stateD = stateQ;
        bxD    = bxQ;
        byD    = byQ;
        cellD  = cellQ;
        binD   = binQ;
        dataD  = dataQ;
        validD = validQ;
        unique case (stateQ)
            StIdle: begin
                if (iStart) begin
                    stateD = StWait;
                    bxD    = '0;
                    byD    = '0;
                    cellD  = '0;
                    binD   = '0;
                end
            end
            StWait: begin
                // Only read a cell the upstream counter has finished writing.
                if ({8'd0, iCellCnt} > cellIdx) stateD = StRd;
            end
            StRd: stateD = StCap;
            StCap: begin
                dataD  = iRdData;
                validD = 1'b1;
                stateD = StHold;
            end
            StHold: begin
                if (iReady) begin
                    validD = 1'b0;
                    stateD = StWait;
                    if (binQ == 4'(BINS - 1)) begin
                        binD = '0;
                        if (cellQ == 2'd3) begin
                            cellD = '0;
                            if (bxQ == 3'(CELLS_X - 2)) begin
                                bxD = '0;
                                if (byQ == 4'(CELLS_Y - 2)) begin
                                    byD    = '0;
                                    stateD = StDone;
                                end else begin
                                    byD = byQ + 4'd1;
                                end
                            end else begin
                                bxD = bxQ + 3'd1;
                            end
                        end else begin
                            cellD = cellQ + 2'd1;
                        end
                    end else begin
                        binD = binQ + 4'd1;
                    end
                end
            end
            StDone: stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    assign oRdEn    = (stateQ == StRd);
    assign oRdAddr  = (stateQ == StRd) ? rdAddr : '0;
    assign oData    = dataQ;
    assign oValid   = validQ;
    assign oBlkX    = bxQ;
    assign oBlkY    = byQ;
    assign oCellSel = cellQ;
    assign oBin     = binQ;
    assign oBusy    = (stateQ == StWait) || (stateQ == StRd) || (stateQ == StCap) ||
                      (stateQ == StHold);
    assign oDone    = (stateQ == StDone);

`ifdef BLOCK_NORM_SUM_EN
    logic [DW+5:0] sumQ;

    // Accumulate at capture so the sum already includes the word being presented;
    // the first word of each block restarts the sum.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            sumQ <= '0;
        end else if (stateQ == StCap) begin
            sumQ <= ((cellQ == 2'd0 && binQ == 4'd0) ? '0 : sumQ) + {6'd0, iRdData};
        end
    end

    assign oBlkSum = sumQ;
`else
    assign oBlkSum = '0;
`endif

endmodule

// File: doc/cell_hist_reader.md
CELL_HIST_READER -- requirements
Module: cell_hist_reader

Interface
REQ-001 SHALL have parameter CELLS_X, default 8, cells per window row.
REQ-002 SHALL have parameter CELLS_Y, default 16, cell rows per window.
REQ-003 SHALL have parameter BINS, default 9, histogram bins per cell.
REQ-004 SHALL have parameter DW, default 16, histogram word width.
REQ-005 Reset iRst_n is synchronous and active-low; clock is iClk.
REQ-006 Ports SHALL be:
 iClk  in  1  clock
 iRst_n  in  1  synchronous active-low reset
 iStart  in  1  begin a window scan (pulse)
 iCellCnt  in  8  count of cells fully written by the upstream cell counter
 oRdEn  out  1  histogram memory read strobe
 oRdAddr  out  11  read address = cell*BINS + bin
 iRdData  in  DW  memory data, valid one cycle after oRdEn
 oData  out  DW  histogram word to the block normaliser
 oValid  out  1  oData valid
 iReady  in  1  downstream accepts oData
 oBlkX  out  3  block column of oData
 oBlkY  out  4  block row of oData
 oCellSel  out  2  cell within block: 0=(0,0), 1=(1,0), 2=(0,1), 3=(1,1)
 oBin  out  4  bin of oData
 oBusy  out  1  scan in progress
 oDone  out  1  one-cycle pulse after the last word is accepted
 oBlkSum  out  DW+6  per-block bin sum (see Configuration)

Function
REQ-007 The FSM SHALL have states IDLE, WAIT, RD, CAP, HOLD and DONE.
REQ-008 IDLE->WAIT SHALL occur on iStart; the block SHALL clear bx, by, cell and bin to 0 and set oBusy.
REQ-009 Current cell index c SHALL be (by+dy)*CELLS_X + (bx+dx), where dx=oCellSel[0] and dy=oCellSel[1].
REQ-010 WAIT->RD SHALL occur only when iCellCnt > c; otherwise the block SHALL stall in WAIT indefinitely.
REQ-011 RD SHALL assert oRdEn for exactly one cycle with oRdAddr = c*BINS + bin, then go to CAP.
REQ-012 CAP SHALL latch iRdData into oData, assert oValid, and go to HOLD.
REQ-013 In HOLD, oData, oValid, oBlkX, oBlkY, oCellSel and oBin SHALL stay stable until iReady=1.
REQ-014 On iReady=1 in HOLD, the block SHALL drop oValid the next cycle and advance in this order: bin (0..BINS-1), then cellSel (0..3), then bx (0..CELLS_X-2), then by (0..CELLS_Y-2). It then goes to WAIT, or to DONE after the final word.
REQ-015 DONE SHALL assert oDone for one cycle, clear oBusy, and return to IDLE.
REQ-016 A scan SHALL emit exactly (CELLS_X-1)*(CELLS_Y-1)*4*BINS words; for the defaults this is 3780.
REQ-017 iStart SHALL be ignored outside IDLE.
REQ-018 At most one read SHALL be outstanding; peak throughput is one word per 4 cycles.
REQ-019 Address arithmetic SHALL be unsigned and SHALL not wrap; the defaults give a maximum address of 1151.

Reset
REQ-020 While iRst_n=0 at a clock edge, the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-021 On reset, oRdEn, oValid, oBusy and oDone SHALL be 0, and oData, oRdAddr, oBlkX, oBlkY, oCellSel, oBin and oBlkSum SHALL be 0.
REQ-022 Reset mid-scan SHALL abort the scan without issuing oDone; an in-flight iRdData SHALL be discarded.

Configuration
REQ-023 With BLOCK_NORM_SUM_EN defined, the block SHALL accumulate oBlkSum as the sum of all accepted words of the current block. oBlkSum is final and valid while the word with oCellSel=3 and oBin=BINS-1 is presented, and the accumulator clears on the first word of the next block.
REQ-024 Without BLOCK_NORM_SUM_EN, oBlkSum SHALL be tied to 0 and no accumulator SHALL be synthesised.

Verification
REQ-025 Reset, then iStart with iCellCnt=128 and iReady=1 -> first addresses 0..8, then 9..17, 72..80 and 81..89. Expect 3780 words, last address 1151, and one oDone pulse.
REQ-026 iCellCnt=8, iStart -> exactly 18 words emitted, then the block stalls in WAIT with oBusy=1. Raising iCellCnt to 9 -> next oRdAddr is 72.
REQ-027 iReady=0 for 5 cycles with oValid=1 -> all outputs are stable and no oRdEn is issued. On iReady=1 the scan advances by exactly one word.
REQ-028 Assert iRst_n=0 after word 100 -> next cycle oBusy=0, oValid=0, state IDLE, and no oDone. A fresh iStart restarts at address 0.
REQ-029 With BLOCK_NORM_SUM_EN and every iRdData=1 -> oBlkSum=36 on the last word of each block. Without the macro -> oBlkSum is always 0.
REQ-030 iStart pulsed mid-scan -> ignored, with the word count and sequence unchanged.
